vx_dispatch_arb: RTL and testbench

//  Round-robin arbiter that merges NUM_REQS dispatch streams (e.g. per-issue-slot
//  or per-warp-group dispatchers) onto one dispatch master port. Sits between the

---
 rtl/vx_dispatch_pkg.sv | 22 ++
 rtl/vx_rr_select.sv | 34 +++
 rtl/vx_dispatch_arb.sv | 99 +++++++++
 tb/tb_vx_dispatch_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dispatch_pkg.sv
// Shared dispatch payload layout used by the arbiter and the dispatch
// interface pack/unpack helpers.
package vx_dispatch_pkg;

    typedef struct packed {
        logic [15:0] uuid;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] PC;
        logic [2:0]  ex_type;
        logic [3:0]  op_type;
        logic [2:0]  op_mod;
        logic        wb;
        logic        use_PC;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
    } dispatch_data_t;

    localparam int DISPATCH_DATAW = $bits(dispatch_data_t);

endpackage

// File: rtl/vx_rr_select.sv
// Combinational round-robin pick: first valid requester at or after ptr_i,
// wrapping explicitly so non-power-of-two N is handled.
module vx_rr_select #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    function automatic int wrap_add(input int p, input int o);
        int s;
        s = p + o;
        return (s >= N) ? s - N : s;
    endfunction

    // Scan from the farthest offset down so the closest valid requester wins.
    always_comb begin
        idx_o   = '0;
        any_o   = 1'b0;
        grant_o = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (valid_i[wrap_add(int'(ptr_i), off)]) begin
                idx_o = IW'(wrap_add(int'(ptr_i), off));
                any_o = 1'b1;
            end
        end
        grant_o[idx_o] = any_o;
    end

endmodule

// File: rtl/vx_dispatch_arb.sv
// Round-robin merge of NUM_REQS dispatch streams onto one registered dispatch
// master port, with source index and a saturating stall counter.
module vx_dispatch_arb
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = DISPATCH_DATAW,
    parameter int PERF_W   = 32,
    parameter int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic [IDXW-1:0]           out_idx,
    input  logic                      out_ready,
    output logic [PERF_W-1:0]         perf_stalls
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a held entry stays stable.

    logic                out_valid_q, out_valid_d;
    logic [DATAW-1:0]    out_data_q,  out_data_d;
    logic [IDXW-1:0]     out_idx_q,   out_idx_d;
    logic [IDXW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [PERF_W-1:0]   perf_q,      perf_d;

    logic [NUM_REQS-1:0] grant;
    logic [IDXW-1:0]     grant_idx;
    logic                grant_any;
    logic                stage_ready;
    logic                fire;
    logic [DATAW-1:0]    sel_data;

    vx_rr_select #(.N(NUM_REQS), .IW(IDXW)) u_select (
        .valid_i (in_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // reset_n gates acceptance so nothing is offered while reset is held.
    assign stage_ready = reset_n & (~out_valid_q | out_ready);
    assign in_ready    = grant & {NUM_REQS{stage_ready}};
    assign fire        = grant_any & stage_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) sel_data = in_data[i*DATAW +: DATAW];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        perf_d      = perf_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_idx_d   = grant_idx;
            rr_ptr_d    = (grant_idx == IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + IDXW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((|in_valid) && !fire && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            rr_ptr_q    <= '0;
            perf_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            perf_q      <= perf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_idx     = out_idx_q;
    assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed bench for vx_dispatch_arb: a 4-requester 32-bit-counter instance
// and a 3-requester 4-bit-counter instance for wrap and saturation cases.
module tb_vx_dispatch_arb;
    import vx_dispatch_pkg::*;

    localparam int DW = DISPATCH_DATAW;

    int n_assert = 0;
    int n_fail   = 0;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // instance A: 4 requesters
    logic [3:0]      a_in_valid;
    logic [4*DW-1:0] a_in_data;
    logic [3:0]      a_in_ready;
    logic            a_out_valid;
    logic [DW-1:0]   a_out_data;
    logic [1:0]      a_out_idx;
    logic            a_out_ready;
    logic [31:0]     a_perf;

    // instance B: 3 requesters, 4-bit stall counter
    logic [2:0]      b_in_valid;
    logic [3*DW-1:0] b_in_data;
    logic [2:0]      b_in_ready;
    logic            b_out_valid;
    logic [DW-1:0]   b_out_data;
    logic [1:0]      b_out_idx;
    logic            b_out_ready;
    logic [3:0]      b_perf;

    vx_dispatch_arb #(.NUM_REQS(4), .PERF_W(32)) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (a_in_valid),
        .in_data     (a_in_data),
        .in_ready    (a_in_ready),
        .out_valid   (a_out_valid),
        .out_data    (a_out_data),
        .out_idx     (a_out_idx),
        .out_ready   (a_out_ready),
        .perf_stalls (a_perf)
    );

    vx_dispatch_arb #(.NUM_REQS(3), .PERF_W(4)) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (b_in_valid),
        .in_data     (b_in_data),
        .in_ready    (b_in_ready),
        .out_valid   (b_out_valid),
        .out_data    (b_out_data),
        .out_idx     (b_out_idx),
        .out_ready   (b_out_ready),
        .perf_stalls (b_perf)
    );

    function automatic logic [DW-1:0] pat(input int i);
        dispatch_data_t d;
        d       = '0;
        d.uuid  = 16'(16'h0100 + i);
        d.wid   = 2'(i);
        d.PC    = 32'h8000_0000 + 32'(i * 4);
        d.imm   = 32'h0101_0101 * 32'(i + 1);
        d.rd    = 5'(i + 1);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int seq_b[3];
        seq_b = '{1, 2, 0};

        reset_n     = 1'b0;
        a_in_valid  = 4'hF;
        a_out_ready = 1'b1;
        a_in_data   = {pat(3), pat(2), pat(1), pat(0)};
        b_in_valid  = 3'b000;
        b_out_ready = 1'b1;
        b_in_data   = {pat(2), pat(1), pat(0)};

        // 1: reset held with all requesters valid
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready",  a_in_ready,  0);
        chk("rst_perf",      a_perf,      0);
        chk("rst_out_idx",   a_out_idx,   0);
        chk("rst_out_data",  a_out_data,  0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // 2: all valid, full throughput, order 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            chk("rr_in_ready", a_in_ready, 128'(1 << (k % 4)));
            @(posedge clk);
            #1;
            chk("rr_out_idx",   a_out_idx,   128'(k % 4));
            chk("rr_out_valid", a_out_valid, 1);
            chk("rr_out_data",  a_out_data,  pat(k % 4));
            @(negedge clk);
            #1;
        end
        chk("rr_perf", a_perf, 0);

        // 3: backpressure with entry from req3 held
        a_out_ready = 1'b0;
        a_in_valid  = 4'b0110;
        #1;
        chk("bp_in_ready", a_in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_perf",      a_perf,      5);
        chk("bp_out_idx",   a_out_idx,   3);
        chk("bp_out_data",  a_out_data,  pat(3));
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_in_ready2", a_in_ready,  0);
        @(negedge clk);
        a_out_ready = 1'b1;
        #1;
        chk("bp_ptr_frozen", a_in_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("bp_idx1", a_out_idx, 1);
        @(negedge clk);
        #1;
        chk("bp_in_ready3", a_in_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("bp_idx2",  a_out_idx, 2);
        chk("bp_perf2", a_perf,    5);

        // 4: sparse requesters, pointer wraps 3 -> 0
        @(negedge clk);
        a_in_valid = 4'b1000;
        #1;
        chk("sp_in_ready3", a_in_ready, 4'b1000);
        @(posedge clk);
        #1;
        chk("sp_idx3", a_out_idx, 3);
        @(negedge clk);
        a_in_valid = 4'b1010;
        #1;
        chk("sp_wrap", a_in_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("sp_idx1",  a_out_idx,  1);
        chk("sp_data1", a_out_data, pat(1));

        // drain, then idle cycles must not move the pointer
        @(negedge clk);
        a_in_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("drain_valid", a_out_valid, 0);
        chk("drain_idx",   a_out_idx,   1);
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 4'hF;
        #1;
        chk("idle_ptr",  a_in_ready, 4'b0100);
        chk("idle_perf", a_perf,     5);
        @(posedge clk);
        #1;
        chk("idle_idx2", a_out_idx, 2);

        // 5: asynchronous reset mid-stream
        @(negedge clk);
        a_out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_out_valid", a_out_valid, 0);
        chk("mrst_out_idx",   a_out_idx,   0);
        chk("mrst_perf",      a_perf,      0);
        chk("mrst_in_ready",  a_in_ready,  0);
        @(negedge clk);
        reset_n     = 1'b1;
        a_out_ready = 1'b1;
        #1;
        chk("mrst_restart", a_in_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("mrst_idx0", a_out_idx, 0);
        @(negedge clk);
        #1;
        chk("mrst_in_ready1", a_in_ready, 4'b0010);
        @(posedge clk);
        #1;
        chk("mrst_idx1", a_out_idx, 1);

        // 6: 3-requester build, counter saturation and non-pow2 wrap
        @(negedge clk);
        a_in_valid  = 4'b0000;
        b_out_ready = 1'b0;
        b_in_valid  = 3'b111;
        @(posedge clk);
        #1;
        chk("b_first_idx",   b_out_idx,   0);
        chk("b_first_valid", b_out_valid, 1);
        chk("b_first_perf",  b_perf,      0);
        repeat (15) @(posedge clk);
        #1;
        chk("b_perf_15", b_perf, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        chk("b_perf_sat", b_perf,    4'hF);
        chk("b_hold_idx", b_out_idx, 0);
        @(negedge clk);
        b_out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("b_in_ready", b_in_ready, 128'(1 << seq_b[k]));
            @(posedge clk);
            #1;
            chk("b_out_idx",  b_out_idx,  128'(seq_b[k]));
            chk("b_out_data", b_out_data, pat(seq_b[k]));
            @(negedge clk);
            #1;
        end
        chk("b_perf_end", b_perf, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
